// File: rtl/phi_edge_buffer.sv
// rtl/phi_edge_buffer.sv - first-word-fall-through edge buffer feeding a PHI incoming port
// Holds values from a control-flow edge; the head is presented as {valid, data}.
module phi_edge_buffer #(
  parameter int ParamBitWidth = 32,
  parameter int ParamDepth    = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              edge_fire,
  input  logic [ParamBitWidth-1:0]          edge_value,
  output logic                              edge_ready,
  input  logic                              consume,
  output logic [ParamBitWidth:0]            out_tagged,
  output logic [$clog2(ParamDepth):0]       occupancy,
  output logic                              overflow,
  input  logic                              overflow_clear
);

  localparam int AW = $clog2(ParamDepth);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DepthCount = CW'(ParamDepth);

  logic [ParamBitWidth-1:0] mem [ParamDepth];
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            rd_ptr;
  logic [CW-1:0]            count;
  logic [CW-1:0]            next_count;
  logic                     ready_q;
  logic                     started_q;
  logic                     overflow_q;
  logic                     push;
  logic                     pop;
  logic                     drop;

  // ready_q is registered, so a full buffer refuses pushes even while popping.
  assign push = edge_fire & ready_q;
  assign pop  = consume & (count != '0);
  // The very first edge after reset sees ready_q=0 by construction; that is not a real drop.
  assign drop = edge_fire & ~ready_q & started_q;

  always_comb begin
    next_count = count;
    if (push && !pop) begin
      next_count = count + 1'b1;
    end else if (pop && !push) begin
      next_count = count - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ready_q    <= 1'b0;
      started_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count     <= next_count;
      ready_q   <= (next_count < DepthCount);
      started_q <= 1'b1;
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (overflow_clear) begin
        overflow_q <= 1'b0;
      end
    end
  end

  // Storage needs no reset: count gates visibility of every entry.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= edge_value;
    end
  end

  assign edge_ready = ready_q;
  assign occupancy  = count;
  assign overflow   = overflow_q;
  assign out_tagged = (count != '0) ? {1'b1, mem[rd_ptr]} : '0;

endmodule

// File: tb/tb_phi_edge_buffer.sv
// tb/tb_phi_edge_buffer.sv - directed self-checking bench for phi_edge_buffer (W=8, D=4)
module tb_phi_edge_buffer;

  logic       clk;
  logic       rst;
  logic       edge_fire;
  logic [7:0] edge_value;
  logic       edge_ready;
  logic       consume;
  logic [8:0] out_tagged;
  logic [2:0] occupancy;
  logic       overflow;
  logic       overflow_clear;

  int checks = 0;
  int errors = 0;

  phi_edge_buffer #(.ParamBitWidth(8), .ParamDepth(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .edge_fire      (edge_fire),
    .edge_value     (edge_value),
    .edge_ready     (edge_ready),
    .consume        (consume),
    .out_tagged     (out_tagged),
    .occupancy      (occupancy),
    .overflow       (overflow),
    .overflow_clear (overflow_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       fire;
    logic [7:0] val;
    logic       cons;
    logic       clr;
    logic [8:0] out;
    logic [2:0] occ;
    logic       rdy;
    logic       ovf;
  } vec_t;

  vec_t tbl[14];
  logic [7:0] q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic f, input logic [7:0] v, input logic c, input logic cl);
    edge_fire      = f;
    edge_value     = v;
    consume        = c;
    overflow_clear = cl;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [8:0] o, input logic [2:0] oc,
                         input logic r, input logic ov);
    chk({tag, " out_tagged"}, 32'(out_tagged), 32'(o));
    chk({tag, " occupancy"},  32'(occupancy),  32'(oc));
    chk({tag, " edge_ready"}, 32'(edge_ready), 32'(r));
    chk({tag, " overflow"},   32'(overflow),   32'(ov));
  endtask

  initial begin
    //          fire val    cons clr  out      occ rdy ovf
    tbl[0]  = '{1'b1, 8'hEE, 1'b0, 1'b0, 9'h000, 3'd0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 8'h5A, 1'b0, 1'b0, 9'h15A, 3'd1, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 9'h000, 3'd0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 9'h000, 3'd0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 8'h01, 1'b0, 1'b0, 9'h101, 3'd1, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 8'h02, 1'b0, 1'b0, 9'h101, 3'd2, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 8'h03, 1'b0, 1'b0, 9'h101, 3'd3, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 8'h04, 1'b0, 1'b0, 9'h101, 3'd4, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 8'h05, 1'b0, 1'b0, 9'h101, 3'd4, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 8'h06, 1'b1, 1'b1, 9'h102, 3'd3, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 9'h102, 3'd3, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 9'h103, 3'd2, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 9'h104, 3'd1, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 9'h000, 3'd0, 1'b1, 1'b0};

    rst = 1'b0;
    edge_fire = 1'b0;
    edge_value = 8'h00;
    consume = 1'b0;
    overflow_clear = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_all("reset", 9'h000, 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].fire, tbl[i].val, tbl[i].cons, tbl[i].clr);
      chk_all($sformatf("vec%0d", i), tbl[i].out, tbl[i].occ, tbl[i].rdy, tbl[i].ovf);
    end

    // Fill, then drain one per cycle.
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      chk($sformatf("fill%0d occupancy", i), 32'(occupancy), 32'(i));
    end
    chk_all("full", 9'h101, 3'd4, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk_all("drain1", 9'h102, 3'd3, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk_all("drain2", 9'h103, 3'd2, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk_all("drain3", 9'h104, 3'd1, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk_all("drain4", 9'h000, 3'd0, 1'b1, 1'b0);

    // Steady push+pop at occupancy 2 wraps both pointers.
    step(1'b1, 8'h10, 1'b0, 1'b0);
    q.push_back(8'h10);
    step(1'b1, 8'h11, 1'b0, 1'b0);
    q.push_back(8'h11);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'(8'h12 + i), 1'b1, 1'b0);
      q.push_back(8'(8'h12 + i));
      void'(q.pop_front());
      chk($sformatf("stream%0d out_tagged", i), 32'(out_tagged), 32'({1'b1, q[0]}));
      chk($sformatf("stream%0d occupancy", i), 32'(occupancy), 32'd2);
    end

    // Asynchronous reset mid-cycle with three entries held.
    step(1'b1, 8'h77, 1'b0, 1'b0);
    chk("pre_rst occupancy", 32'(occupancy), 32'd3);
    edge_fire = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_all("async_rst", 9'h000, 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk_all("post_rst", 9'h000, 3'd0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/phi_edge_buffer.md
PHI_EDGE_BUFFER -- requirements
Module: phi_edge_buffer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clk and rst.
REQ-002 Parameter ParamBitWidth, default 32, SHALL set the data width W.
REQ-003 Parameter ParamDepth, default 2, SHALL set the buffer depth D; legal values are powers of two, 2..16.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 edge_fire  input  1  predecessor block offers edge_value this cycle.
REQ-007 edge_value  input  W  value carried on the control-flow edge.
REQ-008 edge_ready  output  1  buffer can accept a push this cycle.
REQ-009 consume  input  1  downstream PHI enable; pops head when valid.
REQ-010 out_tagged  output  W+1  {valid, data}; MSB valid, [W-1:0] head data; direct feed to a PHI incoming port.
REQ-011 occupancy  output  clog2(D)+1  current entry count, 0..D.
REQ-012 overflow  output  1  sticky flag: a push was dropped.
REQ-013 overflow_clear  input  1  clears overflow.

Function
REQ-014 Push SHALL occur on a rising clk when edge_fire=1 and edge_ready=1; edge_value is written at the write pointer.
REQ-015 Pop SHALL occur on a rising clk when consume=1 and occupancy>0; the read pointer advances.
REQ-016 consume with occupancy=0 SHALL have no effect.
REQ-017 Storage SHALL be first-word-fall-through: out_tagged={1'b1, head} whenever occupancy>0, else all zeros.
REQ-018 Latency SHALL be one cycle: a value pushed at edge N is visible on out_tagged after edge N; there is no combinational bypass from edge_value to out_tagged.
REQ-019 edge_ready SHALL be registered, equal to (occupancy<D) after each edge, with no combinational path from consume.
REQ-020 Simultaneous push and pop SHALL leave occupancy unchanged; head advances and the new value is written at the tail.
REQ-021 When occupancy=D, edge_ready SHALL be 0 even if consume=1 in the same cycle; the freed slot is offered on the next cycle.
REQ-022 Read and write pointers SHALL be clog2(D) bits and wrap modulo D; occupancy SHALL never exceed D or go below 0.
REQ-023 edge_fire=1 with edge_ready=0 SHALL drop edge_value, leave storage and occupancy unchanged, and set overflow on that edge.
REQ-024 overflow SHALL stay set until a clock edge with overflow_clear=1 and no new drop; simultaneous drop and clear SHALL leave overflow=1.
REQ-025 Data SHALL pass unmodified; no width conversion, truncation, or sign handling.

Reset
REQ-026 While rst=1, the block SHALL force pointers=0, occupancy=0, out_tagged=0, overflow=0 and edge_ready=0 immediately, independent of clk.
REQ-027 On the first rising clk after rst deasserts, edge_ready SHALL become 1; any edge_fire coincident with that first edge SHALL be dropped without setting overflow.
REQ-028 Reset asserted mid-operation SHALL discard all stored entries; no stale data may appear on out_tagged after release.

Verification (W=8, D=4)
REQ-029 Reset then one push of 0x5A, consume=0 -> next cycle out_tagged=0x15A, occupancy=1, edge_ready=1.
REQ-030 Push 0x01,0x02,0x03,0x04 back-to-back -> occupancy=4, edge_ready=0; fifth edge_fire with 0x05 -> overflow=1, out_tagged=0x101, 0x05 never appears.
REQ-031 Full buffer, consume=1 for four cycles -> out_tagged 0x101,0x102,0x103,0x104, then 0x000; edge_ready=1 one cycle after the first pop.
REQ-032 Occupancy=2, push and consume every cycle for 10 cycles -> occupancy stays 2, pointers wrap, output order equals input order.
REQ-033 Assert rst asynchronously mid-cycle with occupancy=3 -> out_tagged=0, occupancy=0 and edge_ready=0 before the next clk edge.
REQ-034 Same-cycle drop and overflow_clear -> overflow=1; overflow_clear alone next cycle -> overflow=0.
